// File: rtl/muldiv_unit_pkg.sv
// Shared types and constants for the multiply/divide unit: operation codes,
// FSM states and the latched request payload.
package muldiv_unit_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned CNT_W      = 6;
    localparam int unsigned DIV_ITERS  = 32;

    typedef enum logic [2:0] {
        MD_OP_MULT  = 3'd0,
        MD_OP_MULTU = 3'd1,
        MD_OP_DIV   = 3'd2,
        MD_OP_DIVU  = 3'd3,
        MD_OP_MTHI  = 3'd4,
        MD_OP_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        MD_ST_IDLE = 2'd0,
        MD_ST_MUL  = 2'd1,
        MD_ST_DIV  = 2'd2,
        MD_ST_FIX  = 2'd3
    } md_state_e;

    typedef struct packed {
        md_op_e            op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } md_req_t;

    // Two's-complement negate, kept at full data width.
    function automatic logic [DATA_W-1:0] neg32(input logic [DATA_W-1:0] x);
        return (~x) + DATA_W'(1);
    endfunction

    function automatic logic [DATA_W-1:0] abs32(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? neg32(x) : x;
    endfunction

endpackage

// File: rtl/muldiv_unit_div_core.sv
// Unsigned restoring divider: one quotient bit per enabled cycle, 32 cycles
// after load the quotient and remainder registers hold the final result.
module div_core
    import muldiv_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              en,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] dsr_q, dsr_d;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   diff;

    // The quotient register doubles as the dividend shift register.
    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dsr_d   = dsr_q;
        shifted = {rem_q, quo_q[DATA_W-1]};
        diff    = shifted - {1'b0, dsr_q};
        if (load) begin
            rem_d = '0;
            quo_d = dividend;
            dsr_d = divisor;
        end else if (en) begin
            if (!diff[DATA_W]) begin
                rem_d = diff[DATA_W-1:0];
                quo_d = {quo_q[DATA_W-2:0], 1'b1};
            end else begin
                rem_d = shifted[DATA_W-1:0];
                quo_d = {quo_q[DATA_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dsr_q <= dsr_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage multiply/divide unit owning the architectural HI/LO registers.
// Multi-cycle mult/div with flush cancellation; mthi/mtlo write in IDLE.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        MDOp,
    input  logic [DATA_W-1:0] dInA,
    input  logic [DATA_W-1:0] dInB,
    input  logic              flush,
    output logic              busy,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    md_req_t           req_q, req_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              busy_q;

    logic              div_load;
    logic              div_en;
    logic [DATA_W-1:0] div_dvd;
    logic [DATA_W-1:0] div_dsr;
    logic [DATA_W-1:0] div_quo;
    logic [DATA_W-1:0] div_rem;
    logic [2*DATA_W-1:0] prod;
    logic              is_signed_div;

    // Signed division runs on magnitudes; signs are restored in FIX.
    assign is_signed_div = (md_op_e'(MDOp) == MD_OP_DIV);
    assign div_dvd       = is_signed_div ? abs32(dInA) : dInA;
    assign div_dsr       = is_signed_div ? abs32(dInB) : dInB;

    div_core u_div_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (div_load),
        .en        (div_en),
        .dividend  (div_dvd),
        .divisor   (div_dsr),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        if (req_q.op == MD_OP_MULT) begin
            prod = $unsigned($signed({{DATA_W{req_q.a[DATA_W-1]}}, req_q.a})
                           * $signed({{DATA_W{req_q.b[DATA_W-1]}}, req_q.b}));
        end else begin
            prod = {{DATA_W{1'b0}}, req_q.a} * {{DATA_W{1'b0}}, req_q.b};
        end
    end

    // Next-state, operand latching and HI/LO commit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        div_load = 1'b0;
        div_en   = 1'b0;

        if (flush) begin
            state_d = MD_ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                MD_ST_IDLE: begin
                    if (start) begin
                        case (md_op_e'(MDOp))
                            MD_OP_MULT, MD_OP_MULTU: begin
                                req_d   = '{op: md_op_e'(MDOp), a: dInA, b: dInB};
                                state_d = MD_ST_MUL;
                                cnt_d   = CNT_W'(MUL_CYCLES - 1);
                            end
                            MD_OP_DIV, MD_OP_DIVU: begin
                                req_d    = '{op: md_op_e'(MDOp), a: dInA, b: dInB};
                                state_d  = MD_ST_DIV;
                                cnt_d    = CNT_W'(DIV_ITERS - 1);
                                div_load = 1'b1;
                            end
                            MD_OP_MTHI: hi_d = dInA;
                            MD_OP_MTLO: lo_d = dInA;
                            default: ;
                        endcase
                    end
                end
                MD_ST_MUL: begin
                    if (cnt_q == '0) begin
                        hi_d    = prod[2*DATA_W-1:DATA_W];
                        lo_d    = prod[DATA_W-1:0];
                        state_d = MD_ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                MD_ST_DIV: begin
                    div_en = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = MD_ST_FIX;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                MD_ST_FIX: begin
                    state_d = MD_ST_IDLE;
                    if (req_q.b == '0) begin
                        lo_d = '1;
                        hi_d = req_q.a;
                    end else if (req_q.op == MD_OP_DIV) begin
                        lo_d = (req_q.a[DATA_W-1] ^ req_q.b[DATA_W-1]) ? neg32(div_quo) : div_quo;
                        hi_d = req_q.a[DATA_W-1] ? neg32(div_rem) : div_rem;
                    end else begin
                        lo_d = div_quo;
                        hi_d = div_rem;
                    end
                end
                default: state_d = MD_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '{op: MD_OP_MULT, a: '0, b: '0};
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= (state_d != MD_ST_IDLE);
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: an arithmetic reference model checked every
// cycle, plus literal expectations for the listed scenarios.
module tb_muldiv_unit;

    localparam int MULC = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  MDOp;
    logic [31:0] dInA;
    logic [31:0] dInB;
    logic        flush;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.MUL_CYCLES(MULC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .MDOp  (MDOp),
        .dInA  (dInA),
        .dInB  (dInB),
        .flush (flush),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: countdown of remaining busy cycles and the pending result.
    int          m_rem;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem = 0; m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0;
        end else if (flush) begin
            m_rem = 0;
        end else if (m_rem > 0) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (start) begin
            case (MDOp)
                3'd0: begin
                    longint p;
                    p = longint'($signed(dInA)) * longint'($signed(dInB));
                    {p_hi, p_lo} = p;
                    m_rem = MULC;
                end
                3'd1: begin
                    {p_hi, p_lo} = 64'(dInA) * 64'(dInB);
                    m_rem = MULC;
                end
                3'd2: begin
                    int sa, sb;
                    sa = $signed(dInA);
                    sb = $signed(dInB);
                    if (dInB == 0) begin
                        p_lo = 32'hFFFF_FFFF; p_hi = dInA;
                    end else if (dInA == 32'h8000_0000 && dInB == 32'hFFFF_FFFF) begin
                        p_lo = 32'h8000_0000; p_hi = 0;
                    end else begin
                        p_lo = sa / sb; p_hi = sa % sb;
                    end
                    m_rem = 33;
                end
                3'd3: begin
                    if (dInB == 0) begin
                        p_lo = 32'hFFFF_FFFF; p_hi = dInA;
                    end else begin
                        p_lo = dInA / dInB; p_hi = dInA % dInB;
                    end
                    m_rem = 33;
                end
                3'd4: m_hi = dInA;
                3'd5: m_lo = dInA;
                default: ;
            endcase
        end
    end

    // Single compare process against the model on every settled cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            check("cmp_busy", 32'(busy), 32'(m_rem > 0));
            check("cmp_hi", hi, m_hi);
            check("cmp_lo", lo, m_lo);
        end
    end

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; MDOp = op; dInA = a; dInB = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) begin
            errors++;
            $display("FAIL wait_idle: busy still %0d after %0d cycles", busy, n);
        end
    endtask

    int n;

    initial begin
        rst_n = 1'b0; start = 1'b0; MDOp = 3'd0; dInA = '0; dInB = '0; flush = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        rst_n = 1'b1;

        do_op(3'd0, 32'hFFFF_FFFE, 32'd3);
        wait_idle(n);
        check("mult_cycles", 32'(n), 32'd4);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        do_op(3'd1, 32'hFFFF_FFFE, 32'd3);
        wait_idle(n);
        check("multu_hi", hi, 32'h0000_0002);
        check("multu_lo", lo, 32'hFFFF_FFFA);

        // Operands change after acceptance and a stray mult start arrives mid-div.
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        dInA = 32'd0; dInB = 32'd0;
        repeat (5) @(negedge clk);
        start = 1'b1; MDOp = 3'd0; dInA = 32'd5; dInB = 32'd9;
        @(negedge clk);
        start = 1'b0;
        wait_idle(n);
        check("div_cycles", 32'(n + 6), 32'd33);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        do_op(3'd3, 32'd7, 32'd2);
        wait_idle(n);
        check("divu_lo", lo, 32'd3);
        check("divu_hi", hi, 32'd1);

        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'h0);

        do_op(3'd3, 32'h0000_1234, 32'd0);
        wait_idle(n);
        check("divz_cycles", 32'(n), 32'd33);
        check("divz_lo", lo, 32'hFFFF_FFFF);
        check("divz_hi", hi, 32'h0000_1234);

        do_op(3'd4, 32'hAAAA_5555, 32'd0);
        check("mthi_busy", 32'(busy), 32'd0);
        check("mthi_hi", hi, 32'hAAAA_5555);
        check("mthi_lo", lo, 32'hFFFF_FFFF);

        // Flush at busy cycle 10 of a divu.
        do_op(3'd4, 32'h11, 32'd0);
        do_op(3'd5, 32'h22, 32'd0);
        do_op(3'd3, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_hi", hi, 32'h11);
        check("flush_lo", lo, 32'h22);

        do_op(3'd0, 32'd5, 32'd6);
        wait_idle(n);
        check("post_flush_lo", lo, 32'd30);
        check("post_flush_hi", hi, 32'd0);

        do_op(3'd6, 32'hDEAD_BEEF, 32'd1);
        check("undef_busy", 32'(busy), 32'd0);
        check("undef_hi", hi, 32'd0);

        // Flush together with an mthi start: the write must not land.
        @(negedge clk);
        flush = 1'b1; start = 1'b1; MDOp = 3'd4; dInA = 32'hDEAD_0000;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        check("flush_start_hi", hi, 32'd0);

        // Flush in the final mult cycle: nothing commits.
        do_op(3'd5, 32'd7, 32'd0);
        do_op(3'd0, 32'd3, 32'd3);
        repeat (MULC - 1) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_last_busy", 32'(busy), 32'd0);
        check("flush_last_lo", lo, 32'd7);

        // Asynchronous reset in the middle of a divide.
        do_op(3'd5, 32'h55, 32'd0);
        do_op(3'd3, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("after_rst_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
